// File: rtl/bus_upsizer_pkg.sv
// Shared constants and helpers for the narrow-to-wide stream upsizer.
// Packing order is selected by BUS_UPSIZER_BIG_ENDIAN_EN (defined: first beat in the top slice).
package bus_upsizer_pkg;

  localparam int unsigned DEF_S_DATA_WIDTH = 8;
  localparam int unsigned DEF_M_DATA_WIDTH = 32;

  // Beat counter width; a ratio of 2 still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  // Slice of the wide word that beat number 'beat' occupies.
  function automatic int unsigned slice_index(input int unsigned beat, input int unsigned ratio);
`ifdef BUS_UPSIZER_BIG_ENDIAN_EN
    return ratio - 1 - beat;
`else
    return beat;
`endif
  endfunction

endpackage

// File: rtl/bus_upsizer_out_reg.sv
// Output holding register for the upsizer: holds a packed word until the consumer takes it.
// 'free' means a new word may be loaded this cycle (empty or draining).
module bus_upsizer_out_reg
  import bus_upsizer_pkg::*;
#(
  parameter int unsigned M_DATA_WIDTH = DEF_M_DATA_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [M_DATA_WIDTH-1:0] word,
  input  logic                    m_rdy,
  output logic                    m_val,
  output logic [M_DATA_WIDTH-1:0] m_data,
  output logic                    free
);

  assign free = !m_val || m_rdy;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_val  <= 1'b0;
      m_data <= '0;
    end else if (load) begin
      m_val  <= 1'b1;
      m_data <= word;
    end else if (m_val && m_rdy) begin
      m_val  <= 1'b0;
    end
  end

endmodule

// File: rtl/bus_upsizer.sv
// Packs RATIO consecutive narrow slave beats into one wide master word, one beat per cycle.
// Define BUS_UPSIZER_BIG_ENDIAN_EN for MSB-first packing; default is little-endian.
module bus_upsizer
  import bus_upsizer_pkg::*;
#(
  parameter int unsigned S_DATA_WIDTH = DEF_S_DATA_WIDTH,
  parameter int unsigned M_DATA_WIDTH = DEF_M_DATA_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    s_val,
  input  logic [S_DATA_WIDTH-1:0] s_data,
  output logic                    s_rdy,
  output logic                    m_val,
  output logic [M_DATA_WIDTH-1:0] m_data,
  input  logic                    m_rdy
);

  localparam int unsigned RATIO = M_DATA_WIDTH / S_DATA_WIDTH;
  localparam int unsigned CW    = cnt_width(RATIO);

  generate
    if ((M_DATA_WIDTH % S_DATA_WIDTH) != 0 || RATIO < 2) begin : g_bad_widths
      $error("bus_upsizer: M_DATA_WIDTH must be a multiple (>=2x) of S_DATA_WIDTH");
    end
  endgenerate

  logic [CW-1:0]           cnt;
  logic [M_DATA_WIDTH-1:0] pack_q;
  logic [M_DATA_WIDTH-1:0] word;
  logic                    last_beat;
  logic                    accept;
  logic                    out_free;

  assign last_beat = (cnt == CW'(RATIO - 1));
  assign s_rdy     = !last_beat || out_free;
  assign accept    = s_val && s_rdy;

  // Pack register with the current beat's slice replaced by s_data.
  // NOTE: assign every always_comb output a default first so no path infers a latch.
  always_comb begin
    word = pack_q;
    for (int k = 0; k < int'(RATIO); k++) begin
      if (cnt == CW'(k)) begin
        word[slice_index(k, RATIO)*S_DATA_WIDTH +: S_DATA_WIDTH] = s_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      pack_q <= '0;
    end else if (accept) begin
      pack_q <= word;
      cnt    <= last_beat ? '0 : cnt + CW'(1);
    end
  end

  bus_upsizer_out_reg #(
    .M_DATA_WIDTH (M_DATA_WIDTH)
  ) u_out_reg (
    .clock  (clock),
    .reset  (reset),
    .load   (accept && last_beat),
    .word   (word),
    .m_rdy  (m_rdy),
    .m_val  (m_val),
    .m_data (m_data),
    .free   (out_free)
  );

endmodule

// File: tb/tb_bus_upsizer.sv
// Self-checking bench for bus_upsizer: directed test-plan cases plus random traffic,
// checked by a scoreboard fed from a beat-list reference model.
module tb_bus_upsizer;
  import bus_upsizer_pkg::*;

  localparam int unsigned S = DEF_S_DATA_WIDTH;
  localparam int unsigned M = DEF_M_DATA_WIDTH;
  localparam int unsigned R = M / S;

  logic         clock = 1'b0;
  logic         reset;
  logic         s_val;
  logic [S-1:0] s_data;
  logic         s_rdy;
  logic         m_val;
  logic [M-1:0] m_data;
  logic         m_rdy;

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  bit           mon_en = 1'b0;
  logic [S-1:0] beat_q[$];
  logic [M-1:0] exp_q[$];
  logic [M-1:0] last_word = '0;

  bus_upsizer #(.S_DATA_WIDTH(S), .M_DATA_WIDTH(M)) dut (
    .clock  (clock),
    .reset  (reset),
    .s_val  (s_val),
    .s_data (s_data),
    .s_rdy  (s_rdy),
    .m_val  (m_val),
    .m_data (m_data),
    .m_rdy  (m_rdy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word is just the list of its beats placed by beat number.
  function automatic logic [M-1:0] pack_beats(input logic [S-1:0] b[$]);
    logic [M-1:0] w = '0;
    for (int k = 0; k < int'(R); k++) begin
`ifdef BUS_UPSIZER_BIG_ENDIAN_EN
      w = w | (M'(b[k]) << ((int'(R) - 1 - k) * int'(S)));
`else
      w = w | (M'(b[k]) << (k * int'(S)));
`endif
    end
    return w;
  endfunction

  // Records accepted beats just after the negedge; the output monitor runs first.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (reset === 1'b1) begin
        beat_q.delete();
        exp_q.delete();
      end else if (mon_en && s_val && s_rdy) begin
        beat_q.push_back(s_data);
        if (beat_q.size() == R) begin
          exp_q.push_back(pack_beats(beat_q));
          beat_q.delete();
        end
      end
    end
  end

  // Output monitor: predicts m_val/s_rdy from model occupancy and pops words on transfer.
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en && reset === 1'b0) begin
        bit pending;
        pending = (exp_q.size() != 0);
        check("m_val", 64'(m_val), 64'(pending));
        check("s_rdy", 64'(s_rdy),
              64'((beat_q.size() != R - 1) || !pending || m_rdy));
        if (m_val && m_rdy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(m_data), 64'hDEAD_0000_0000);
          end else begin
            check("m_data", 64'(m_data), 64'(exp_q.pop_front()));
          end
          last_word = m_data;
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic send_beat(input logic [S-1:0] d);
    int waited = 0;
    s_val  = 1'b1;
    s_data = d;
    @(negedge clock);
    while (!s_rdy && waited < 200) begin
      waited++;
      @(negedge clock);
    end
    if (!s_rdy) check("send_timeout", 64'(s_rdy), 64'd1);
    cycle();
    s_val  = 1'b0;
    s_data = S'($urandom);
  endtask

  task automatic idle(input int n);
    s_val = 1'b0;
    repeat (n) begin
      s_data = S'($urandom);
      cycle();
    end
  endtask

  task automatic do_reset(input logic [S-1:0] junk);
    reset  = 1'b1;
    s_val  = 1'b1;
    s_data = junk;
    cycle();
    reset = 1'b0;
    s_val = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    s_val  = 1'b1;
    s_data = 8'hEE;
    m_rdy  = 1'b0;
    cycle();
    reset  = 1'b0;
    s_val  = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);
    check("reset_m_val", 64'(m_val), 64'd0);
    check("reset_m_data", 64'(m_data), 64'd0);
    check("reset_s_rdy", 64'(s_rdy), 64'd1);
    cycle();

    // Basic pack
    m_rdy = 1'b1;
    send_beat(8'h10); send_beat(8'h01); send_beat(8'h02); send_beat(8'h04);
    idle(2);
`ifdef BUS_UPSIZER_BIG_ENDIAN_EN
    check("basic_word", 64'(last_word), 64'h1001_0204);
`else
    check("basic_word", 64'(last_word), 64'h0402_0110);
`endif

    // Streaming: two words with no gap
    for (int i = 0; i < 8; i++) send_beat(S'(i));
    idle(2);
`ifdef BUS_UPSIZER_BIG_ENDIAN_EN
    check("stream_word", 64'(last_word), 64'h0405_0607);
`else
    check("stream_word", 64'(last_word), 64'h0706_0504);
`endif

    // Backpressure: first word stalls, three beats still accepted, fourth blocked
    send_beat(8'h10); send_beat(8'h01); send_beat(8'h02); send_beat(8'h04);
    m_rdy = 1'b0;
    send_beat(8'h20); send_beat(8'h21); send_beat(8'h22);
    s_val  = 1'b1;
    s_data = 8'h23;
    repeat (3) begin
      @(negedge clock);
      check("bp_s_rdy_low", 64'(s_rdy), 64'd0);
      check("bp_m_val_held", 64'(m_val), 64'd1);
`ifdef BUS_UPSIZER_BIG_ENDIAN_EN
      check("bp_m_data_held", 64'(m_data), 64'h1001_0204);
`else
      check("bp_m_data_held", 64'(m_data), 64'h0402_0110);
`endif
      cycle();
    end
    m_rdy = 1'b1;
    @(negedge clock);
    check("bp_s_rdy_release", 64'(s_rdy), 64'd1);
    cycle();
    s_val = 1'b0;
    @(negedge clock);
    check("bp_next_valid", 64'(m_val), 64'd1);
`ifdef BUS_UPSIZER_BIG_ENDIAN_EN
    check("bp_next_word", 64'(m_data), 64'h2021_2223);
`else
    check("bp_next_word", 64'(m_data), 64'h2322_2120);
`endif
    cycle();
    idle(1);

    // Gaps between beats
    send_beat(8'hAA); idle(3); send_beat(8'hBB); send_beat(8'hCC); idle(1); send_beat(8'hDD);
    idle(2);
`ifdef BUS_UPSIZER_BIG_ENDIAN_EN
    check("gap_word", 64'(last_word), 64'hAABB_CCDD);
`else
    check("gap_word", 64'(last_word), 64'hDDCC_BBAA);
`endif

    // Reset mid-word discards partial beats
    send_beat(8'h11); send_beat(8'h22);
    do_reset(8'h99);
    send_beat(8'h33); send_beat(8'h44); send_beat(8'h55); send_beat(8'h66);
    idle(2);
`ifdef BUS_UPSIZER_BIG_ENDIAN_EN
    check("rst_mid_word", 64'(last_word), 64'h3344_5566);
`else
    check("rst_mid_word", 64'(last_word), 64'h6655_4433);
`endif

    // Random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      s_val  = 1'($urandom_range(0, 3) != 0);
      s_data = S'($urandom);
      m_rdy  = 1'($urandom_range(0, 2) != 0);
      cycle();
    end
    s_val = 1'b0;
    m_rdy = 1'b1;
    idle(5);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_upsizer.md
Name: bus_upsizer

Overview:
- Width-converting stream adapter: packs RATIO consecutive narrow slave beats (S_DATA_WIDTH) into one wide master word (M_DATA_WIDTH).
- Valid/ready handshake on both sides, single clock domain.
- Sits between a narrow byte-stream producer and a wide-bus consumer.
- Sustains one slave beat per cycle while the master side keeps up.

Parameters:
- S_DATA_WIDTH, 8, slave (input) beat width in bits.
- M_DATA_WIDTH, 32, master (output) word width in bits. Must be an integer multiple of S_DATA_WIDTH, with ratio >= 2.
- RATIO (localparam), M_DATA_WIDTH/S_DATA_WIDTH, beats per output word.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- s_val  input  1  slave beat valid.
- s_data  input  S_DATA_WIDTH  slave beat data.
- s_rdy  output  1  block can accept a slave beat this cycle.
- m_val  output  1  packed output word valid.
- m_data  output  M_DATA_WIDTH  packed output word.
- m_rdy  input  1  downstream accepts the word this cycle.

Behaviour:
- Handshakes:
  - Slave transfer occurs on a rising edge with s_val && s_rdy.
  - Master transfer occurs on a rising edge with m_val && m_rdy.
- Reset (synchronous, priority over everything):
  - beat counter = 0, pack register = 0, m_val = 0, m_data = 0.
  - A partially assembled word is discarded.
  - A pending output word is dropped.
- State:
  - Beat counter cnt, range 0..RATIO-1.
  - Pack register of M_DATA_WIDTH bits.
  - Output register (m_data, m_val).
- Packing (default, little-endian): beat k of a word is written to bits [k*S_DATA_WIDTH +: S_DATA_WIDTH].
- Non-final beat (cnt < RATIO-1):
  - Written into the pack register; cnt increments.
  - Output register unaffected.
- Final beat (cnt == RATIO-1):
  - Assembled word (pack register with the final slice replaced by s_data) is loaded into m_data on the same edge.
  - m_val set to 1; cnt returns to 0.
- Output hold rules:
  - m_data and m_val stay stable while m_val && !m_rdy.
  - On a master transfer with no simultaneous final beat, m_val clears to 0.
  - m_data keeps its last value after m_val clears.
- s_rdy is combinational: s_rdy = (cnt != RATIO-1) || !m_val || m_rdy.
  - Non-final beats are always accepted, even while the output is stalled.
  - The final beat is accepted only if the output register is empty or draining this cycle.
- Simultaneous master transfer and final slave beat: new word loads, m_val stays 1. This gives back-to-back words with zero bubble.
- Latency: m_val rises on the edge that accepts the final beat and is visible the following cycle.
- s_val low: no state change on the slave side. Gaps between beats are allowed at any position.
- s_data is ignored when s_val is low.
- No combinational path from s_val/s_data to m_val/m_data.

Optional Feature:
- Macro: BUS_UPSIZER_BIG_ENDIAN_EN.
- Defined: MSB-first packing. Beat k goes to bits [(RATIO-1-k)*S_DATA_WIDTH +: S_DATA_WIDTH], so the first beat lands in the top slice.
- Undefined: little-endian packing as in Behaviour.
- Handshake and timing are identical in both builds.

Decomposition:
- Package bus_upsizer_pkg holds:
  - default width constants (S 8, M 32);
  - a ratio/counter-width helper function ($clog2 of RATIO, min 1);
  - slice-index helper selecting endianness.
- Natural sub-module: bus_upsizer_out_reg, the output holding register.
  - Inputs: load, word, m_rdy.
  - Outputs: m_val, m_data, and a "free" signal used in the s_rdy equation.
- Top level holds the counter and pack register.

Test Plan:
- Reset: reset=1 for 1 cycle -> m_val=0, m_data=0x00000000, s_rdy=1; a beat presented during reset is not captured.
- Basic pack: m_rdy=1; beats 0x10,0x01,0x02,0x04 on 4 consecutive cycles -> one m_val pulse with m_data=0x04020110. With BUS_UPSIZER_BIG_ENDIAN_EN the word is 0x10010204.
- Streaming: 8 beats 0x00..0x07 continuous, m_rdy=1 -> words 0x03020100 then 0x07060504; s_rdy never drops; no bubble between words.
- Backpressure: m_rdy=0 after first word 0x04020110, feed 4 more beats -> 3 beats accepted, s_rdy=0 at 4th; m_data held. Raise m_rdy -> first word transfers, 4th beat accepted same cycle, next word valid following cycle.
- Gaps: beats 0xAA,(idle 3 cycles),0xBB,0xCC,(idle),0xDD -> m_data=0xDDCCBBAA.
- Reset mid-word: 2 beats 0x11,0x22 then reset, then 0x33,0x44,0x55,0x66 -> m_data=0x66554433 (no stale bytes).
